// File: rtl/flash_boot_loader.sv
// Boot-time copier: streams bytes from SPI flash (READ 0x03) and writes them to RAM as little-endian words.
// Optional running checksum of written words is enabled by defining FLASH_BOOT_LOADER_CHECKSUM_EN.
module flash_boot_loader #(
    parameter int          TransferByteCount = 4096,
    parameter logic [23:0] FlashStartAddress = 24'h0,
    parameter logic [31:0] RamStartAddress   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic        flash_clk,
    input  logic        flash_miso,
    output logic        flash_mosi,
    output logic        flash_cs_n,
    output logic        ramio_enable,
    output logic [1:0]  ramio_write_type,
    output logic [31:0] ramio_address,
    output logic [31:0] ramio_data_in,
    input  logic        ramio_busy
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    localparam int CntW = $clog2(TransferByteCount + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]      state;
    logic            phase;      // 0: SPI clock low half, 1: high half
    logic [4:0]      bit_cnt;
    logic [23:0]     shift_reg;
    logic [31:0]     word;
    logic [CntW-1:0] byte_cnt;
    logic [31:0]     ram_addr;
    logic            wait_skip;

    // phase is cleared outside the shifting states, so the SPI clock idles low there.
    assign flash_clk  = phase;
    assign flash_mosi = ((state == S_CMD) || (state == S_ADDR)) && shift_reg[23];

    // NOTE: every register, data path included, is reset so the outputs are defined
    // from the first cycle; all state updates use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            phase            <= 1'b0;
            bit_cnt          <= '0;
            shift_reg        <= '0;
            word             <= '0;
            byte_cnt         <= '0;
            ram_addr         <= '0;
            wait_skip        <= 1'b0;
            done             <= 1'b0;
            flash_cs_n       <= 1'b1;
            ramio_enable     <= 1'b0;
            ramio_write_type <= 2'b00;
            ramio_address    <= '0;
            ramio_data_in    <= '0;
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
            checksum         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        flash_cs_n <= 1'b0;
                        shift_reg  <= {8'h03, 16'h0000};
                        bit_cnt    <= 5'd7;
                        phase      <= 1'b0;
                        byte_cnt   <= '0;
                        ram_addr   <= RamStartAddress;
                        state      <= S_CMD;
                    end
                end

                S_CMD, S_ADDR, S_DATA: begin
                    phase <= ~phase;
                    // End of the high half: take miso and advance to the next bit.
                    if (phase) begin
                        shift_reg <= {shift_reg[22:0], flash_miso};
                        bit_cnt   <= bit_cnt - 5'd1;
                        if (bit_cnt == 5'd0) begin
                            case (state)
                                S_CMD: begin
                                    shift_reg <= FlashStartAddress;
                                    bit_cnt   <= 5'd23;
                                    state     <= S_ADDR;
                                end
                                S_ADDR: begin
                                    bit_cnt <= 5'd7;
                                    state   <= S_DATA;
                                end
                                default: begin
                                    // Newest byte enters at the top, so byte 0 ends up in [7:0].
                                    word     <= {shift_reg[6:0], flash_miso, word[31:8]};
                                    byte_cnt <= byte_cnt + 1'b1;
                                    bit_cnt  <= 5'd7;
                                    if (byte_cnt[1:0] == 2'b11) state <= S_WRITE;
                                end
                            endcase
                        end
                    end
                end

                S_WRITE: begin
                    if (!ramio_busy) begin
                        ramio_enable     <= 1'b1;
                        ramio_write_type <= 2'b11;
                        ramio_address    <= ram_addr;
                        ramio_data_in    <= word;
                        ram_addr         <= ram_addr + 32'd4;
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
                        checksum         <= checksum + word;
`endif
                        wait_skip        <= 1'b1;
                        state            <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    ramio_enable     <= 1'b0;
                    ramio_write_type <= 2'b00;
                    // Give ramio one cycle to raise busy before trusting it.
                    if (wait_skip) begin
                        wait_skip <= 1'b0;
                    end else if (!ramio_busy) begin
                        if (byte_cnt == CntW'(TransferByteCount)) begin
                            flash_cs_n <= 1'b1;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            bit_cnt <= 5'd7;
                            state   <= S_DATA;
                        end
                    end
                end

                default: begin
                    flash_cs_n <= 1'b1;
                    phase      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Self-checking bench for flash_boot_loader: SPI flash model, randomized ramio busy, scoreboard of RAM writes.
// Define FLASH_BOOT_LOADER_CHECKSUM_EN to also check the checksum port.
module tb_flash_boot_loader;

    localparam int          N  = 16;
    localparam logic [23:0] FA = 24'h10;
    localparam logic [31:0] RA = 32'hFFFF_FFF8;   // exercises 32-bit address wrap

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic        flash_clk;
    logic        flash_miso = 1'b0;
    logic        flash_mosi;
    logic        flash_cs_n;
    logic        ramio_enable;
    logic [1:0]  ramio_write_type;
    logic [31:0] ramio_address;
    logic [31:0] ramio_data_in;
    logic        ramio_busy = 1'b0;
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    flash_boot_loader #(
        .TransferByteCount(N),
        .FlashStartAddress(FA),
        .RamStartAddress(RA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .done(done),
        .flash_clk(flash_clk),
        .flash_miso(flash_miso),
        .flash_mosi(flash_mosi),
        .flash_cs_n(flash_cs_n),
        .ramio_enable(ramio_enable),
        .ramio_write_type(ramio_write_type),
        .ramio_address(ramio_address),
        .ramio_data_in(ramio_data_in),
        .ramio_busy(ramio_busy)
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Flash contents and expected-write scoreboard
    logic [7:0]  mem [0:255];
    logic [63:0] exp_q [$];
    logic [31:0] exp_sum;

    // SPI flash model, mode 0: sample mosi on rising edge, shift miso out on falling edge.
    int          rx_bits = 0;
    int          tx_bits = 0;
    logic [31:0] rx_sr = '0;
    logic [31:0] cmd_addr_seen = '0;

    always @(posedge flash_clk or negedge flash_clk or posedge flash_cs_n) begin
        if (flash_cs_n === 1'b1) begin
            rx_bits = 0;
            tx_bits = 0;
        end else if (flash_cs_n === 1'b0) begin
            if (flash_clk === 1'b1) begin
                if (rx_bits < 32) begin
                    rx_sr = {rx_sr[30:0], flash_mosi};
                    rx_bits++;
                    if (rx_bits == 32) cmd_addr_seen = rx_sr;
                end
            end else if (rx_bits >= 32) begin
                logic [7:0] b;
                b = mem[8'(rx_sr[7:0] + 8'(tx_bits / 8))];
                flash_miso = b[7 - (tx_bits % 8)];
                tx_bits++;
            end
        end
    end

    int fclk_edges = 0;
    always @(posedge flash_clk) fclk_edges++;

    // ramio busy generator: 0 = never busy, 1 = random, 2 = always busy
    int busy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (busy_mode)
            0:       ramio_busy = 1'b0;
            1:       ramio_busy = ($urandom_range(0, 2) == 0);
            default: ramio_busy = 1'b1;
        endcase
    end

    // Monitor: every write request is popped against the scoreboard.
    int en_total = 0;
    always @(negedge clk) begin
        if (ramio_enable === 1'b1) begin
            en_total++;
            check("write_type", 64'(ramio_write_type), 64'(2'b11));
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write expected",
                         ramio_address, ramio_data_in);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("write_addr", 64'(ramio_address), 64'(e[63:32]));
                check("write_data", 64'(ramio_data_in), 64'(e[31:0]));
            end
        end
    end

    // Reference: word n is flash bytes FA+4n..FA+4n+3, little-endian, at RA+4n.
    task automatic push_expected();
        logic [31:0] w;
        logic [7:0]  base;
        exp_sum = '0;
        for (int n = 0; n < N / 4; n++) begin
            base = 8'(FA[7:0] + 8'(4 * n));
            w = {mem[8'(base + 8'd3)], mem[8'(base + 8'd2)], mem[8'(base + 8'd1)], mem[base]};
            exp_q.push_back({RA + 32'(4 * n), w});
            exp_sum += w;
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done_and_check(input int base_en);
        int c;
        c = 0;
        while (done !== 1'b1 && c < 5000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("done", 64'(done), 64'd1);
        check("cs_n_after_done", 64'(flash_cs_n), 64'd1);
        check("write_count", 64'(en_total - base_en), 64'(N / 4));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(exp_sum));
`endif
    endtask

    initial begin
        int base_en;
        int lat;
        int bad;
        int c;
        int edges;

        randomize_mem();
        {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} = {8'h13, 8'h00, 8'h01, 8'h00};
        {mem[8'h14], mem[8'h15], mem[8'h16], mem[8'h17]} = {8'hEF, 8'h00, 8'h40, 8'h00};

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_done", 64'(done), 64'd0);
        check("rst_cs_n", 64'(flash_cs_n), 64'd1);
        check("rst_flash_clk", 64'(flash_clk), 64'd0);
        check("rst_mosi", 64'(flash_mosi), 64'd0);
        check("rst_enable", 64'(ramio_enable), 64'd0);
        check("rst_write_type", 64'(ramio_write_type), 64'd0);
        check("rst_address", 64'(ramio_address), 64'd0);
        check("rst_data_in", 64'(ramio_data_in), 64'd0);
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'd0);
`endif

        // Run 1: known pattern, no busy, first-word latency and command/address bits
        base_en = en_total;
        push_expected();
        check("model_word0", exp_q[0], {RA, 32'h0001_0013});
        check("model_word1", exp_q[1], {RA + 32'd4, 32'h0040_00EF});
        pulse_start();
        lat = 0;
        for (int k = 1; k <= 400 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (ramio_enable === 1'b1) lat = k;
        end
        check("first_write_latency", 64'(lat), 64'd129);
        wait_done_and_check(base_en);
        check("mosi_cmd_addr", 64'(cmd_addr_seen), 64'({8'h03, FA}));

        // Run 2: busy held during the first Write for 20 cycles
        do_reset();
        randomize_mem();
        base_en = en_total;
        push_expected();
        busy_mode = 2;
        pulse_start();
        bad = 0;
        for (int k = 1; k <= 148; k++) begin
            @(posedge clk);
            #1;
            if (k > 128 && (ramio_enable !== 1'b0 || flash_clk !== 1'b0)) bad++;
        end
        check("busy_hold_idle", 64'(bad), 64'd0);
        check("busy_hold_no_write", 64'(en_total - base_en), 64'd0);
        busy_mode = 0;
        wait_done_and_check(base_en);

        // Run 3: reset in the middle of byte 5, then a full restart
        do_reset();
        randomize_mem();
        push_expected();
        busy_mode = 1;
        pulse_start();
        c = 0;
        while (tx_bits < 36 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("reached_byte5", 64'(tx_bits >= 36), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs_n", 64'(flash_cs_n), 64'd1);
        check("abort_enable", 64'(ramio_enable), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        base_en = en_total;
        push_expected();
        pulse_start();
        wait_done_and_check(base_en);

        // Run 4: start held high throughout and after done
        do_reset();
        randomize_mem();
        base_en = en_total;
        push_expected();
        @(posedge clk);
        #1 start = 1'b1;
        wait_done_and_check(base_en);
        edges = fclk_edges;
        repeat (100) @(posedge clk);
        #1;
        check("no_flash_after_done", 64'(fclk_edges - edges), 64'd0);
        check("no_write_after_done", 64'(en_total - base_en), 64'(N / 4));
        check("done_sticky", 64'(done), 64'd1);
        start = 1'b0;
        busy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
